operand_tf_stream: RTL
======================

# operand_tf_stream

Parametrised streaming operand transformer that generalises the fixed 32-element / 16-lane, 1:2-or-1:4 operand transform into a configurable serializer. It accepts one warp of sign-magnitude elements plus micro-scales over a valid/ready handshake and buffers it. It then emits the warp over `WARP_SIZE/NUM_LANES` output beats. Each lane carries a two's-complement element with its resolved micro-scale, and the block feeds the temporal operand registers in front of the lane datapath.

## Interface

- `ELEM_WIDTH_IN`, default 8: input element width (1 sign bit + magnitude).
- `ELEM_WIDTH_OUT`, default 9: output element width, two's complement; must be ≥ `ELEM_WIDTH_IN`.
- `SCALE_WIDTH`, default 8: micro-scale width.
- `WARP_SIZE`, default 32: elements per warp; power of two.
- `NUM_LANES`, default 16: elements per output beat; power of two dividing `WARP_SIZE`.
- `NUM_SCALES`, default 16: micro-scales per warp; power of two.

Ports (clock and reset first):

- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: warp payload valid.
- `in_ready`, out, 1: block accepts a warp.
- `in_mode`, in, 2: scale sharing. 0 = 1:1, 1 = 1:2, 2 = 1:4, 3 = 1:8.
- `in_scales`, in, `NUM_SCALES*SCALE_WIDTH`: micro-scales, index 0 in the LSBs.
- `in_elems`, in, `WARP_SIZE*ELEM_WIDTH_IN`: elements, index 0 in the LSBs.
- `out_valid`, out, 1: beat valid.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_elems`, out, `NUM_LANES*ELEM_WIDTH_OUT`: converted elements for this beat.
- `out_scales`, out, `NUM_LANES*SCALE_WIDTH`: per-lane resolved micro-scale.
- `out_beat`, out, `$clog2(NUM_BEATS)` (min 1): beat index.
- `out_last`, out, 1: final beat of the warp.
- `cfg_err`, out, 1: single-cycle pulse on accepting a warp whose mode needs more than `NUM_SCALES` scales.

## Operation

- `NUM_BEATS = WARP_SIZE/NUM_LANES`.
- FSM has two states, IDLE and DRAIN.
  - IDLE: `in_ready`=1. An input handshake captures elements, scales and mode into the warp buffer, clears the beat counter and moves to DRAIN.
  - DRAIN: `out_valid`=1. Each output handshake increments the beat counter. The handshake on beat `NUM_BEATS-1` returns the FSM to IDLE.
- Element `e` in beat `b`, lane `l`: `e = b*NUM_LANES + l`.
- Element conversion (sign-magnitude to two's complement):
  - Magnitude is zero-extended to `ELEM_WIDTH_OUT`, then negated if the sign bit is set.
  - Negative zero produces 0.
- Scale resolution: scale index = `(e >> mode) mod NUM_SCALES`.
- `cfg_err` pulses when `(WARP_SIZE >> mode) > NUM_SCALES`. Processing continues with the wrapped index.
- `out_beat` equals the beat counter. `out_last` = (beat counter == `NUM_BEATS-1`) while in DRAIN.
- `out_valid` held low with `out_ready` high: no state change. `out_ready` low: all outputs hold stable.
- `NUM_BEATS`=1: DRAIN lasts exactly one handshake, and `out_last` is always 1 when `out_valid` is 1.

## Timing

- Reset values: FSM IDLE, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_beat`=0, `cfg_err`=0, `out_elems`=0, `out_scales`=0. The buffer contents are don't-care.
- Latency: input handshake in cycle N gives `out_valid`=1 with beat 0 in cycle N+1.
- Throughput without the prefetch option: `NUM_BEATS+1` cycles per warp, because of one IDLE bubble.
- `out_*` data is derived only from registers (buffer plus beat counter). There is no combinational path from `in_*` to `out_*`.
- `in_ready` does not depend combinationally on `out_ready`.
- Reset mid-DRAIN: the next cycle is IDLE, `out_valid`=0, and the partial warp is discarded.

## Configuration

- `OPERAND_TF_PREFETCH_EN` defined:
  - Adds a shadow warp buffer. `in_ready` = shadow buffer empty, in both IDLE and DRAIN.
  - On the last-beat handshake, a full shadow buffer moves into the main buffer. DRAIN continues with beat 0 on the next cycle, with no bubble.
  - An input handshake and a last-beat handshake in the same cycle: the incoming warp goes to the main buffer directly if the shadow buffer is empty.
  - Sustained throughput is `NUM_BEATS` cycles per warp.
- Not defined: single buffer, behaviour exactly as in Operation.

## Structure

- Shared package `operand_tf_pkg` holds:
  - the `sharing_mode_e` enum (`SHARE_1_1`, `SHARE_1_2`, `SHARE_1_4`, `SHARE_1_8`);
  - the `tf_state_e` FSM enum;
  - the default width and count constants.
- One sub-module, `operand_tf_sm2tc`: parametrised combinational sign-magnitude to two's-complement converter, instantiated once per lane.

## Test plan

- Reset, then mode 1:2, elements `e=i`, scales `s=0x10+i`, `out_ready`=1 → beat 0: lanes 0–15 give elems 0..15 and scales 0x10,0x10,0x11,…,0x17. Beat 1: elems 16..31, scales 0x18..0x1F. `out_last` is set on beat 1.
- Element `0x85` → `-5` (0x1FB at 9 bits). Element `0x80` (negative zero) → 0. Element `0x7F` → 127.
- Mode 1:1 with 16 scales → `cfg_err` pulses for one cycle at acceptance. Element 17 gets scale index 1.
- Mode 1:8 → elements 0–7 use scale 0 and 24–31 use scale 3.
- `out_ready` toggled 1,0,0,1 during DRAIN → outputs stay stable while stalled. Exactly 2 beats are delivered, and `in_ready` rises only after `out_last` is accepted.
- Back-to-back warps with `out_ready`=1:
  - Without the macro, 3 cycles per warp.
  - With `OPERAND_TF_PREFETCH_EN`, 2 cycles per warp with no `out_valid` gap.
  - Assert `rst` mid-DRAIN → `out_valid`=0 on the next cycle.

Source files
------------

// File: rtl/operand_tf_pkg.sv
// operand_tf_pkg: shared enums, default sizes and scale-coverage helper for the operand transformer
package operand_tf_pkg;
  typedef enum logic [1:0] {SHARE_1_1, SHARE_1_2, SHARE_1_4, SHARE_1_8} sharing_mode_e;
  typedef enum logic {IDLE, DRAIN} tf_state_e;
  localparam int DEF_ELEM_WIDTH_IN = 8;
  localparam int DEF_ELEM_WIDTH_OUT = 9;
  localparam int DEF_SCALE_WIDTH = 8;
  localparam int DEF_WARP_SIZE = 32;
  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_NUM_SCALES = 16;
  function automatic logic wraps_scales(int warp, int scales, logic [1:0] mode);
    return (warp >> mode) > scales;
  endfunction
endpackage

// File: rtl/operand_tf_sm2tc.sv
// operand_tf_sm2tc: combinational sign-magnitude to two's-complement element converter
module operand_tf_sm2tc #(
  parameter int W_IN = 8,
  parameter int W_OUT = 9
) (
  input  logic [W_IN-1:0]  sm,
  output logic [W_OUT-1:0] tc
);
  logic [W_OUT-1:0] mag;
  always_comb begin
    mag = W_OUT'(sm[W_IN-2:0]);
    tc = sm[W_IN-1] ? -mag : mag;
  end
endmodule

// File: rtl/operand_tf_stream.sv
// operand_tf_stream: buffers a warp and streams it as converted, scale-resolved beats; OPERAND_TF_PREFETCH_EN adds a shadow warp buffer
module operand_tf_stream
  import operand_tf_pkg::*;
#(
  parameter int ELEM_WIDTH_IN = DEF_ELEM_WIDTH_IN,
  parameter int ELEM_WIDTH_OUT = DEF_ELEM_WIDTH_OUT,
  parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int WARP_SIZE = DEF_WARP_SIZE,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int NUM_SCALES = DEF_NUM_SCALES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_mode,
  input  logic [NUM_SCALES*SCALE_WIDTH-1:0]   in_scales,
  input  logic [WARP_SIZE*ELEM_WIDTH_IN-1:0]  in_elems,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LANES*ELEM_WIDTH_OUT-1:0] out_elems,
  output logic [NUM_LANES*SCALE_WIDTH-1:0]    out_scales,
  output logic [(WARP_SIZE/NUM_LANES > 1 ? $clog2(WARP_SIZE/NUM_LANES) : 1)-1:0] out_beat,
  output logic                                out_last,
  output logic                                cfg_err
);
  localparam int NB = WARP_SIZE / NUM_LANES;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int EW = $clog2(WARP_SIZE) + 1;
  localparam int SW = NUM_SCALES > 1 ? $clog2(NUM_SCALES) : 1;
  localparam int EB = WARP_SIZE * ELEM_WIDTH_IN;
  localparam int SB = NUM_SCALES * SCALE_WIDTH;
  tf_state_e state;
  sharing_mode_e buf_mode;
  logic [EB-1:0] buf_elems;
  logic [SB-1:0] buf_scales;
  logic [BW-1:0] beat;
  logic in_hs, out_hs, last, load_in, load_sh;
  assign out_valid = state == DRAIN;
  assign in_hs = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign last = beat == BW'(NB - 1);
  assign out_last = out_valid && last;
  assign out_beat = beat;
`ifdef OPERAND_TF_PREFETCH_EN
  sharing_mode_e sh_mode;
  logic [EB-1:0] sh_elems;
  logic [SB-1:0] sh_scales;
  logic sh_full;
  assign in_ready = !sh_full;
  assign load_in = in_hs && (state == IDLE || (out_hs && last));
  assign load_sh = out_hs && last && sh_full;
  always_ff @(posedge clk)
    if (in_hs && !load_in) begin
      sh_elems <= in_elems;
      sh_scales <= in_scales;
      sh_mode <= sharing_mode_e'(in_mode);
    end
  always_ff @(posedge clk)
    if (rst) sh_full <= 1'b0;
    else if (in_hs && !load_in) sh_full <= 1'b1;
    else if (load_sh) sh_full <= 1'b0;
`else
  assign in_ready = state == IDLE;
  assign load_in = in_hs;
  assign load_sh = 1'b0;
`endif
  always_ff @(posedge clk)
    if (load_in) begin
      buf_elems <= in_elems;
      buf_scales <= in_scales;
      buf_mode <= sharing_mode_e'(in_mode);
    end
`ifdef OPERAND_TF_PREFETCH_EN
    else if (load_sh) begin
      buf_elems <= sh_elems;
      buf_scales <= sh_scales;
      buf_mode <= sh_mode;
    end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= (load_in || load_sh) ? DRAIN : (out_hs && last) ? IDLE : state;
      beat <= (load_in || load_sh || (out_hs && last)) ? '0 : out_hs ? beat + BW'(1) : beat;
      cfg_err <= in_hs && wraps_scales(WARP_SIZE, NUM_SCALES, in_mode);
    end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [EW-1:0] e;
    logic [SW-1:0] si;
    logic [ELEM_WIDTH_OUT-1:0] tc;
    assign e = EW'(beat) * EW'(NUM_LANES) + EW'(l);
    assign si = SW'(int'(e >> buf_mode) % NUM_SCALES);
    operand_tf_sm2tc #(.W_IN(ELEM_WIDTH_IN), .W_OUT(ELEM_WIDTH_OUT)) u_cvt (
      .sm(buf_elems[int'(e)*ELEM_WIDTH_IN +: ELEM_WIDTH_IN]),
      .tc(tc)
    );
    assign out_elems[l*ELEM_WIDTH_OUT +: ELEM_WIDTH_OUT] = out_valid ? tc : '0;
    assign out_scales[l*SCALE_WIDTH +: SCALE_WIDTH] = out_valid ? buf_scales[int'(si)*SCALE_WIDTH +: SCALE_WIDTH] : '0;
  end
endmodule
